udma_stream_framer: RTL and testbench

Stream source that sits directly upstream of the uDMA filter stream input. It takes raw peripheral samples over a valid/ready handshake and groups them into frames of a programmed length. Each beat is tagged with stream ID, datasize and start/end-of-frame flags. Output goes through a 2-entry buffer, so the peripheral side never sees a combinational path from the filter's ready.

---
 rtl/udma_stream_framer_pkg.sv | 17 +
 rtl/udma_stream_fifo2.sv | 70 +++++++
 rtl/udma_stream_framer.sv | 140 ++++++++++++++
 tb/tb_udma_stream_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_stream_framer_pkg.sv
// Shared types and constants for the uDMA stream framer and its FIFO.
// Datasize encoding matches the filter's stream datasize field.
package udma_stream_framer_pkg;

  localparam int STREAM_ID_WIDTH = 4;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_RUN   = 2'd1,
    FR_CLOSE = 2'd2
  } framer_state_e;

endpackage

// File: rtl/udma_stream_fifo2.sv
// Two-entry register FIFO with a generic payload and a synchronous flush.
// Head entry is always slot0, so the output is a plain register.
module udma_stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      slot0_d = '0;
      slot1_d = '0;
      count_d = 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = data_i;
          else                 slot1_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        // Both only possible at count 1: the new entry replaces the head.
        2'b11: slot0_d = data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign data_o  = slot0_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/udma_stream_framer.sv
// Groups peripheral samples into tagged frames (sot/eot, ID, datasize) and
// feeds them to the uDMA filter stream input through a 2-entry buffer.
module udma_stream_framer
  import udma_stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FILTID_WIDTH = STREAM_ID_WIDTH,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    sys_clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_en_i,
  input  logic                    cfg_clr_i,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len_i,
  input  logic [FILTID_WIDTH-1:0] cfg_stream_id_i,
  input  logic [1:0]              cfg_datasize_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [FILTID_WIDTH-1:0] stream_id_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [1:0]              datasize_o,
  output logic                    valid_o,
  output logic                    sot_o,
  output logic                    eot_o,
  input  logic                    ready_i,
  output logic                    frame_done_o,
  output logic                    busy_o,
  output logic [15:0]             frame_cnt_o
);

  localparam int PW = FILTID_WIDTH + 2 + 2 + DATA_WIDTH;

  framer_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [FILTID_WIDTH-1:0] id_q, id_d;
  logic [1:0]              ds_q, ds_d;
  logic [15:0]             fcnt_q, fcnt_d;

  logic                    accept;
  logic                    pop;
  logic                    first_beat;
  logic                    beat_eot;
  logic [LEN_WIDTH-1:0]    cur_len;
  logic [FILTID_WIDTH-1:0] cur_id;
  logic [1:0]              cur_ds;
  logic [PW-1:0]           push_payload;
  logic [PW-1:0]           head;
  logic [1:0]              fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  // The first sample of a frame uses live config; later ones use the latch.
  assign first_beat = (cnt_q == '0);
  assign cur_len    = first_beat ? cfg_frame_len_i : len_q;
  assign cur_id     = first_beat ? cfg_stream_id_i : id_q;
  assign cur_ds     = first_beat ? cfg_datasize_i  : ds_q;
  assign beat_eot   = (cnt_q == cur_len);

  assign in_ready_o   = (state_q != FR_IDLE) && !fifo_full;
  assign accept       = in_valid_i && in_ready_o;
  assign valid_o      = !fifo_empty;
  assign pop          = valid_o && ready_i;
  assign frame_done_o = pop && eot_o;
  assign busy_o       = (state_q != FR_IDLE) || (fifo_count != 2'd0);
  assign frame_cnt_o  = fcnt_q;

  assign push_payload = {cur_id, cur_ds, first_beat, beat_eot, in_data_i};
  assign {stream_id_o, datasize_o, sot_o, eot_o, data_o} = head;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    id_d    = id_q;
    ds_d    = ds_q;
    fcnt_d  = fcnt_q;

    if (accept) begin
      if (first_beat) begin
        len_d = cfg_frame_len_i;
        id_d  = cfg_stream_id_i;
        ds_d  = cfg_datasize_i;
      end
      cnt_d = beat_eot ? '0 : cnt_q + LEN_WIDTH'(1);
    end

    if (frame_done_o) fcnt_d = fcnt_q + 16'd1;

    // Leaving RUN looks at the post-acceptance counter so a sample taken in
    // the same cycle enable drops is never stranded in an unterminated frame.
    unique case (state_q)
      FR_IDLE:  if (cfg_en_i) state_d = FR_RUN;
      FR_RUN:   if (!cfg_en_i) state_d = (cnt_d == '0) ? FR_IDLE : FR_CLOSE;
      FR_CLOSE: if (accept && beat_eot) state_d = FR_IDLE;
      default:  state_d = FR_IDLE;
    endcase

    if (cfg_clr_i) begin
      state_d = FR_IDLE;
      cnt_d   = '0;
      fcnt_d  = 16'd0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FR_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      ds_q    <= 2'd0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      id_q    <= id_d;
      ds_q    <= ds_d;
      fcnt_q  <= fcnt_d;
    end
  end

  udma_stream_fifo2 #(
    .WIDTH(PW)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rstn_i  (rstn_i),
    .flush_i (cfg_clr_i),
    .push_i  (accept),
    .data_i  (push_payload),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_udma_stream_framer.sv
// Self-checking bench for udma_stream_framer: a hand table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_udma_stream_framer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en, clr;
  logic [15:0] flen;
  logic [3:0]  sid;
  logic [1:0]  ds;
  logic [31:0] din;
  logic        vin;
  logic        in_ready;
  logic [3:0]  id_o;
  logic [31:0] data_o;
  logic [1:0]  ds_o;
  logic        valid_o, sot_o, eot_o;
  logic        rdy;
  logic        done;
  logic        busy;
  logic [15:0] fcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udma_stream_framer dut (
    .sys_clk_i       (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (en),
    .cfg_clr_i       (clr),
    .cfg_frame_len_i (flen),
    .cfg_stream_id_i (sid),
    .cfg_datasize_i  (ds),
    .in_data_i       (din),
    .in_valid_i      (vin),
    .in_ready_o      (in_ready),
    .stream_id_o     (id_o),
    .data_o          (data_o),
    .datasize_o      (ds_o),
    .valid_o         (valid_o),
    .sot_o           (sot_o),
    .eot_o           (eot_o),
    .ready_i         (rdy),
    .frame_done_o    (done),
    .busy_o          (busy),
    .frame_cnt_o     (fcnt)
  );

  // Reference model: expected output beats in arrival order plus the
  // position inside the currently open input frame.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  ds;
    logic        sot;
    logic        eot;
  } beat_t;

  beat_t       mq[$];
  int          mState;
  int          mPos;
  logic [15:0] mLen;
  logic [3:0]  mId;
  logic [1:0]  mDs;
  int          mFrames;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mInReady();
    return (mState != 0) && (mq.size() < 2);
  endfunction

  task automatic modelReset();
    mq.delete();
    mState  = 0;
    mPos    = 0;
    mLen    = '0;
    mId     = '0;
    mDs     = '0;
    mFrames = 0;
  endtask

  task automatic modelCheck();
    logic expDone;
    expDone = (mq.size() > 0) ? (rdy && mq[0].eot) : 1'b0;
    checkOutput("in_ready", in_ready, mInReady());
    checkOutput("valid", valid_o, mq.size() > 0);
    if (mq.size() > 0) begin
      checkOutput("data", data_o, mq[0].data);
      checkOutput("sot", sot_o, mq[0].sot);
      checkOutput("eot", eot_o, mq[0].eot);
      checkOutput("stream_id", id_o, mq[0].id);
      checkOutput("datasize", ds_o, mq[0].ds);
    end
    checkOutput("frame_done", done, expDone);
    checkOutput("busy", busy, (mState != 0) || (mq.size() > 0));
    checkOutput("frame_cnt", fcnt, mFrames[15:0]);
  endtask

  task automatic modelUpdate();
    logic  acc;
    beat_t b;
    acc = vin && mInReady();
    b   = '{default: '0};
    if (clr) begin
      mq.delete();
      mState  = 0;
      mPos    = 0;
      mFrames = 0;
      return;
    end
    if (mq.size() > 0 && rdy) begin
      if (mq[0].eot) mFrames++;
      void'(mq.pop_front());
    end
    if (acc) begin
      if (mPos == 0) begin
        mLen = flen;
        mId  = sid;
        mDs  = ds;
      end
      b.data = din;
      b.id   = mId;
      b.ds   = mDs;
      b.sot  = (mPos == 0);
      b.eot  = (mPos == int'(mLen));
      mPos   = b.eot ? 0 : mPos + 1;
      mq.push_back(b);
    end
    case (mState)
      0: if (en) mState = 1;
      1: if (!en) mState = (mPos == 0) ? 0 : 2;
      2: if (acc && b.eot) mState = 0;
      default: mState = 0;
    endcase
  endtask

  // Called just after a falling edge: drive, settle, compare with the model.
  task automatic applyStimulus(input logic e, input logic c, input logic v,
                               input logic [31:0] d, input logic r);
    en  = e;
    clr = c;
    vin = v;
    din = d;
    rdy = r;
    #1;
    modelCheck();
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic cycle(input logic e, input logic c, input logic v,
                       input logic [31:0] d, input logic r);
    applyStimulus(e, c, v, d, r);
    tick();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        expInReady;
    logic        expValid;
    logic [31:0] expData;
    logic        expSot;
    logic        expEot;
    logic        expDone;
    logic [15:0] expCnt;
  } vec_t;

  vec_t tbl[11];
  int   accCnt;

  initial begin
    // Length field 3, eight back-to-back samples with ready held high.
    tbl[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 32'h2, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 32'h3, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 32'h4, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 32'h5, 1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[6]  = '{1'b1, 32'h6, 1'b1, 1'b1, 32'h5, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 32'h7, 1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd2};

    rstn = 1'b0;
    en = 1'b0; clr = 1'b0; vin = 1'b0; din = '0; rdy = 1'b0;
    flen = 16'd3; sid = 4'd1; ds = 2'd2;
    modelReset();
    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_sot", sot_o, 0);
    checkOutput("rst_eot", eot_o, 0);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_id", id_o, 0);
    checkOutput("rst_ds", ds_o, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fcnt", fcnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] table: length field 3, two frames");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b0, tbl[i].v, tbl[i].d, 1'b1);
      checkOutput($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].expInReady);
      checkOutput($sformatf("tbl%0d_valid", i), valid_o, tbl[i].expValid);
      if (tbl[i].expValid) begin
        checkOutput($sformatf("tbl%0d_data", i), data_o, tbl[i].expData);
        checkOutput($sformatf("tbl%0d_sot", i), sot_o, tbl[i].expSot);
        checkOutput($sformatf("tbl%0d_eot", i), eot_o, tbl[i].expEot);
      end
      checkOutput($sformatf("tbl%0d_done", i), done, tbl[i].expDone);
      checkOutput($sformatf("tbl%0d_fcnt", i), fcnt, tbl[i].expCnt);
      tick();
    end

    $display("[TB] length field 0: single-beat frames");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    flen = 16'd0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h20 + i, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("len0_frame_cnt", fcnt, 3);
    tick();

    $display("[TB] backpressure");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    flen = 16'd7;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    accCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100 + i, 1'b0);
      if (vin && in_ready) accCnt++;
      tick();
    end
    checkOutput("bp_accepted", accCnt, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_in_ready_held", in_ready, 0);
    checkOutput("bp_head", data_o, 32'h100);
    tick();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] enable drop mid-frame");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    flen = 16'd4;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h31, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h32, 1'b1);
    for (int i = 3; i <= 7; i++) cycle(1'b0, 1'b0, 1'b1, 32'h30 + i, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h38, 1'b1);
    checkOutput("close_in_ready", in_ready, 0);
    checkOutput("close_busy", busy, 0);
    checkOutput("close_frame_cnt", fcnt, 1);
    tick();

    $display("[TB] stream ID change mid-frame");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    flen = 16'd2;
    sid  = 4'd2;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h41, 1'b1);
    sid = 4'd5;
    cycle(1'b1, 1'b0, 1'b1, 32'h42, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h43, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h44, 1'b1);
    checkOutput("id_old_frame_data", data_o, 32'h43);
    checkOutput("id_old_frame", id_o, 2);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("id_new_frame_sot", sot_o, 1);
    checkOutput("id_new_frame", id_o, 5);
    tick();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] clear with buffer full");
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    flen = 16'd0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h50, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    flen = 16'd7;
    cycle(1'b1, 1'b0, 1'b1, 32'h51, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h52, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h53, 1'b0);
    checkOutput("pre_clr_fcnt", fcnt, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("clr_valid", valid_o, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_fcnt", fcnt, 0);
    checkOutput("clr_in_ready", in_ready, 0);
    checkOutput("clr_done", done, 0);
    tick();
    flen = 16'd0;
    cycle(1'b1, 1'b0, 1'b1, 32'hAA, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("clr_next_sot", sot_o, 1);
    checkOutput("clr_next_data", data_o, 32'hAA);
    tick();

    $display("[TB] asynchronous reset mid-frame");
    flen = 16'd5;
    cycle(1'b1, 1'b0, 1'b1, 32'hBB, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_valid", valid_o, 1);
    rstn = 1'b0;
    #1;
    checkOutput("arst_valid", valid_o, 0);
    checkOutput("arst_data", data_o, 0);
    checkOutput("arst_sot", sot_o, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_fcnt", fcnt, 0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] randomized traffic");
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic e;
      e    = ($urandom_range(0, 29) == 0) ? ~en : en;
      flen = 16'($urandom_range(0, 4));
      sid  = 4'($urandom);
      ds   = 2'($urandom_range(0, 2));
      cycle(e, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
